// File: rtl/inst_cache.sv
// inst_cache: direct-mapped, one-word-per-line instruction cache between the
// fetch unit and the memory controller, with one-cycle hits and single-word fills.
module inst_cache #(
  parameter int ADDR_WIDTH = 17,
  parameter int INDEX_BITS = 8
) (
  input  logic        clockIn,
  input  logic        resetIn,
  input  logic        readyIn,
  input  logic        clearIn,
  input  logic        ifFlag,
  input  logic [31:0] ifAddr,
  output logic        ifOk,
  output logic [31:0] ifInst,
  output logic        memFlag,
  output logic [31:0] memAddr,
  input  logic        memOk,
  input  logic [31:0] memData
);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;
  typedef enum logic {IDLE, MISS} state_t;
  state_t                 state_q;
  logic [LINES-1:0]       valid_q;
  logic [TAG_BITS-1:0]    tag_q  [LINES];
  logic [31:0]            data_q [LINES];
  logic [31:0]            req_addr_q;
  logic [INDEX_BITS-1:0]  if_index, req_index;
  logic [TAG_BITS-1:0]    if_tag, req_tag;
  logic                   hit, fill;
  logic                   unused_bits;
  assign if_index  = ifAddr[INDEX_BITS+1:2];
  assign if_tag    = ifAddr[ADDR_WIDTH-1:INDEX_BITS+2];
  assign req_index = req_addr_q[INDEX_BITS+1:2];
  assign req_tag   = req_addr_q[ADDR_WIDTH-1:INDEX_BITS+2];
  assign hit       = ifFlag && valid_q[if_index] && tag_q[if_index] == if_tag;
  // A fill needs memOk on a live cycle; a coincident clear discards the word.
  assign fill      = readyIn && !clearIn && state_q == MISS && memOk;
  assign memFlag   = state_q == MISS && !memOk;
  assign memAddr   = state_q == MISS ? req_addr_q : '0;
  assign unused_bits = ^{ifAddr[31:ADDR_WIDTH], ifAddr[1:0]};
  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      ifOk       <= 1'b0;
      ifInst     <= '0;
      req_addr_q <= '0;
    end else if (readyIn) begin
      if (clearIn) begin
        state_q <= IDLE;
        ifOk    <= 1'b0;
      end else if (state_q == IDLE) begin
        ifOk <= hit;
        if (hit) ifInst <= data_q[if_index];
        else if (ifFlag) begin
          req_addr_q <= {ifAddr[31:2], 2'b00};
          state_q    <= MISS;
        end
      end else if (memOk) begin
        valid_q[req_index] <= 1'b1;
        ifInst             <= memData;
        ifOk               <= 1'b1;
        state_q            <= IDLE;
      end else ifOk <= 1'b0;
    end
  end
  always_ff @(posedge clockIn) begin
    if (fill) begin
      tag_q[req_index]  <= req_tag;
      data_q[req_index] <= memData;
    end
  end
endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: table-driven fetch vectors plus hand-written clear, stall,
// back-to-back and reset sequences for inst_cache.
module tb_inst_cache;
  logic        clk = 1'b0;
  logic        rst_n, ready, clear, if_flag, mem_ok, if_ok, mem_flag;
  logic [31:0] if_addr, mem_data, if_inst, mem_addr;
  int checks = 0;
  int failures = 0;

  inst_cache dut (
    .clockIn(clk), .resetIn(rst_n), .readyIn(ready), .clearIn(clear),
    .ifFlag(if_flag), .ifAddr(if_addr), .ifOk(if_ok), .ifInst(if_inst),
    .memFlag(mem_flag), .memAddr(mem_addr), .memOk(mem_ok), .memData(mem_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        miss;
    logic [31:0] word;
    logic [31:0] inst;
  } vec_t;
  vec_t v [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one fetch and serve a miss with a 5-cycle memory latency.
  task automatic fetch(input string name, input logic [31:0] addr, input logic exp_miss,
                       input logic [31:0] word, input logic [31:0] inst);
    if_flag = 1'b1;
    if_addr = addr;
    chk({name, "_pre_memflag"}, {31'b0, mem_flag}, 32'h0);
    tick();
    chk({name, "_memflag"}, {31'b0, mem_flag}, {31'b0, exp_miss});
    if (exp_miss) begin
      chk({name, "_memaddr"}, mem_addr, {addr[31:2], 2'b00});
      chk({name, "_ifok_wait"}, {31'b0, if_ok}, 32'h0);
      repeat (4) tick();
      chk({name, "_memflag_held"}, {31'b0, mem_flag}, 32'h1);
      mem_ok = 1'b1;
      mem_data = word;
      #1;
      chk({name, "_memflag_drop"}, {31'b0, mem_flag}, 32'h0);
      tick();
      mem_ok = 1'b0;
      mem_data = 32'h0;
    end
    chk({name, "_ifok"}, {31'b0, if_ok}, 32'h1);
    chk({name, "_ifinst"}, if_inst, inst);
    if_flag = 1'b0;
    tick();
    chk({name, "_ifok_pulse"}, {31'b0, if_ok}, 32'h0);
  endtask

  logic [31:0] b2b_addr [4];
  logic [31:0] b2b_inst [4];

  initial begin
    rst_n = 1'b0; ready = 1'b1; clear = 1'b0; if_flag = 1'b0;
    if_addr = '0; mem_ok = 1'b0; mem_data = '0;
    v[0]  = '{32'h0000_1000, 1'b1, 32'h0050_0093, 32'h0050_0093};
    v[1]  = '{32'h0000_1000, 1'b0, 32'h0,         32'h0050_0093};
    v[2]  = '{32'h0000_1400, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    v[3]  = '{32'h0000_1000, 1'b1, 32'h0050_0093, 32'h0050_0093};
    v[4]  = '{32'h0000_1002, 1'b0, 32'h0,         32'h0050_0093};
    v[5]  = '{32'h0000_2004, 1'b1, 32'h1111_1111, 32'h1111_1111};
    v[6]  = '{32'h0000_2008, 1'b1, 32'h2222_2222, 32'h2222_2222};
    v[7]  = '{32'h0000_200C, 1'b1, 32'h3333_3333, 32'h3333_3333};
    v[8]  = '{32'h0000_2004, 1'b0, 32'h0,         32'h1111_1111};
    v[9]  = '{32'h0002_1000, 1'b0, 32'h0,         32'h0050_0093};
    v[10] = '{32'h0000_1400, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};

    repeat (2) tick();
    chk("rst_ifok", {31'b0, if_ok}, 32'h0);
    chk("rst_ifinst", if_inst, 32'h0);
    chk("rst_memflag", {31'b0, mem_flag}, 32'h0);
    chk("rst_memaddr", mem_addr, 32'h0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 11; i++)
      fetch($sformatf("v%0d", i), v[i].addr, v[i].miss, v[i].word, v[i].inst);

    // Clear during a miss with memOk low; the coincident ifFlag must be ignored.
    if_flag = 1'b1; if_addr = 32'h5000;
    tick();
    chk("clr1_memflag", {31'b0, mem_flag}, 32'h1);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr1_memflag_after", {31'b0, mem_flag}, 32'h0);
    chk("clr1_ifok", {31'b0, if_ok}, 32'h0);
    if_flag = 1'b0;
    tick();
    chk("clr1_ifok_later", {31'b0, if_ok}, 32'h0);

    // Clear coincident with memOk: no fill, so a refetch still misses.
    if_flag = 1'b1; if_addr = 32'h5000;
    tick();
    chk("clr2_memflag", {31'b0, mem_flag}, 32'h1);
    if_flag = 1'b0;
    clear = 1'b1; mem_ok = 1'b1; mem_data = 32'h0BAD_0BAD;
    tick();
    clear = 1'b0; mem_ok = 1'b0; mem_data = 32'h0;
    chk("clr2_ifok", {31'b0, if_ok}, 32'h0);
    chk("clr2_memflag_after", {31'b0, mem_flag}, 32'h0);
    fetch("clr2_refetch", 32'h5000, 1'b1, 32'h5555_5555, 32'h5555_5555);

    // Stall while ifOk is high: output pulse holds.
    if_flag = 1'b1; if_addr = 32'h2004;
    tick();
    if_flag = 1'b0;
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall_ifok%0d", i), {31'b0, if_ok}, 32'h1);
      chk($sformatf("stall_ifinst%0d", i), if_inst, 32'h1111_1111);
    end
    ready = 1'b1;
    tick();
    chk("stall_release_ifok", {31'b0, if_ok}, 32'h0);

    // Stall with memOk present: fill waits for readyIn.
    if_flag = 1'b1; if_addr = 32'h6000;
    tick();
    chk("stmiss_memflag", {31'b0, mem_flag}, 32'h1);
    ready = 1'b0; mem_ok = 1'b1; mem_data = 32'h6666_6666;
    repeat (2) tick();
    chk("stmiss_ifok_held", {31'b0, if_ok}, 32'h0);
    ready = 1'b1;
    tick();
    mem_ok = 1'b0; mem_data = 32'h0; if_flag = 1'b0;
    chk("stmiss_ifok", {31'b0, if_ok}, 32'h1);
    chk("stmiss_ifinst", if_inst, 32'h6666_6666);
    tick();
    fetch("stmiss_hit", 32'h6000, 1'b0, 32'h0, 32'h6666_6666);

    // Back-to-back hits, one new address per cycle.
    b2b_addr = '{32'h2004, 32'h2008, 32'h200C, 32'h6000};
    b2b_inst = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h6666_6666};
    if_flag = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if_addr = b2b_addr[i];
      tick();
      chk($sformatf("b2b_ifok%0d", i), {31'b0, if_ok}, 32'h1);
      chk($sformatf("b2b_ifinst%0d", i), if_inst, b2b_inst[i]);
      chk($sformatf("b2b_memflag%0d", i), {31'b0, mem_flag}, 32'h0);
    end
    if_flag = 1'b0;
    tick();

    // Asynchronous reset in the middle of a miss.
    if_flag = 1'b1; if_addr = 32'h3000;
    tick();
    chk("rstmiss_memflag", {31'b0, mem_flag}, 32'h1);
    if_flag = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstmiss_memflag_low", {31'b0, mem_flag}, 32'h0);
    chk("rstmiss_ifok", {31'b0, if_ok}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    fetch("post_rst", 32'h1000, 1'b1, 32'h0050_0093, 32'h0050_0093);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/inst_cache.md
Name: inst_cache

Overview:
- Direct-mapped, one-word-per-line instruction cache between the instruction-fetch unit (upstream) and the memory controller's icache port (downstream).
- Serves hits in one cycle.
- On a miss, issues a single word fetch to the memory controller, fills the line and returns the instruction.
- Obeys the global clear (branch mispredict) and ready (memory stall) signals the same way the memory controller does.

Parameters:
- ADDR_WIDTH, 17: physical address bits used for tag/index; upper address bits are ignored.
- INDEX_BITS, 8: log2 of line count (default 256 lines of 32 bits).

Ports:
- clockIn  input  1  clock; all state updates on the rising edge.
- resetIn  input  1  reset, asynchronous, active-low.
- readyIn  input  1  global ready; when 0, all sequential state holds.
- clearIn  input  1  mispredict flush; aborts any in-flight request.
- ifFlag  input  1  fetch request from the IF unit.
- ifAddr  input  32  byte address of the requested instruction.
- ifOk  output  1  one-cycle pulse: ifInst is valid.
- ifInst  output  32  returned instruction word.
- memFlag  output  1  word-fetch request to the memory controller.
- memAddr  output  32  word-aligned fetch address to the memory controller.
- memOk  input  1  memory controller done pulse (registered on its side).
- memData  input  32  fetched word, valid when memOk=1.

Behaviour:
- Address split:
  - offset = ifAddr[1:0], ignored.
  - index = ifAddr[INDEX_BITS+1:2].
  - tag = ifAddr[ADDR_WIDTH-1:INDEX_BITS+2].
- Storage:
  - valid[2^INDEX_BITS] flops.
  - tag and data arrays, not reset.
- Reset (resetIn=0, asynchronous): state=IDLE, all valid=0, ifOk=0, ifInst=0, reqAddr=0.
  - memFlag=0 follows combinationally from state.
  - Reset mid-miss abandons the miss without a fill.
- Priority each edge: reset > readyIn=0 (hold everything, including ifOk) > clearIn > normal FSM.
- clearIn=1 with readyIn=1:
  - state<=IDLE, ifOk<=0.
  - The pending miss is dropped, with no fill even if memOk=1 in the same cycle.
  - An ifFlag presented that cycle is ignored.
- FSM states IDLE, MISS.
- IDLE:
  - ifOk<=0 by default.
  - If ifFlag and valid[index] and tag match (hit): ifInst<=data[index], ifOk<=1, stay IDLE. Hit latency is 1 cycle, and back-to-back hits are allowed, one per cycle.
  - If ifFlag and miss: reqAddr<={ifAddr[31:2],2'b00}, state<=MISS, ifOk stays 0.
- MISS:
  - memFlag = (state==MISS) && !memOk, combinational, so the request drops in the same cycle as memOk. This prevents the controller (back in its IDLE) from re-launching the fetch.
  - memAddr = reqAddr while in MISS, 0 otherwise.
  - On memOk=1 edge:
    - data[reqIndex]<=memData, tag[reqIndex]<=reqTag, valid[reqIndex]<=1.
    - ifInst<=memData, ifOk<=1, state<=IDLE.
  - Miss latency to ifOk = memory latency + 1 cycle after memOk.
  - ifFlag/ifAddr changes during MISS are ignored; the IF unit holds its request until ifOk.
- ifOk is high for exactly one readyIn=1 cycle. If ifFlag is still high in the ifOk cycle, it is treated as a new request.
- A fill to an index that holds another tag overwrites it (no replacement choice).
- No invalidation other than reset; instruction memory is read-only.

Test Plan:
- Reset:
  - Drive resetIn=0 mid-miss → ifOk=0, memFlag=0 immediately.
  - After release, fetch 0x1000 misses (memFlag=1, memAddr=0x1000).
- Cold miss then hit:
  - Fetch 0x1000, memOk with memData=0x00500093 after 5 cycles → memFlag low in the memOk cycle, ifOk=1 with ifInst=0x00500093 the next cycle.
  - Refetch 0x1000 → ifOk the next cycle, same data, memFlag stays 0.
- Conflict (INDEX_BITS=8):
  - After filling 0x1000, fetch 0x1400 → miss, fill 0xDEADBEEF.
  - Fetch 0x1000 → miss again.
  - Fetch 0x1002 → hit returns the 0x1000 line.
- Clear:
  - clearIn during MISS with memOk=0 → memFlag=0 next cycle, no ifOk.
  - Repeat with clearIn coincident with memOk → no ifOk, and refetch of the same address misses.
- Stall:
  - readyIn=0 for 3 cycles while ifOk=1 → ifOk/ifInst/state held.
  - readyIn=0 with memOk=1 → no fill until readyIn=1.
- Back-to-back hits:
  - ifFlag held high over 4 cached addresses changing each cycle → ifOk=1 each cycle, each ifInst matching the address from the prior cycle.
